// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: fetch FSM state encodings, default widths and the NOP word.
package cpu_defs;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: reads imem at the current PC over req/ack and presents the
// word to decode over valid/ready, handling misaligned PCs, timeouts and flushes.
module fetch_unit
  import cpu_defs::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              fetch_reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              pc_write_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              decode_ready,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] err_pc
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  fetch_state_t state, state_nxt;
  logic [7:0]   tmo_cnt;
  logic         flushed;

  logic start_fetch;
  logic misaligned;
  logic accept;
  logic drop;
  logic timed_out;
  logic aborted;

  // A flush seen in this cycle counts the same as one remembered from earlier
  assign aborted     = flushed | flush;
  assign pc_write_en = (state == FETCH_HOLD) & decode_ready & ~flush;

  always_ff @(posedge clk or posedge fetch_reset) begin
    if (fetch_reset) state <= FETCH_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    misaligned  = 1'b0;
    accept      = 1'b0;
    drop        = 1'b0;
    timed_out   = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (fetch_en && !flush) begin
          if (pc_in[1:0] != 2'b00) begin
            misaligned = 1'b1;
          end else begin
            start_fetch = 1'b1;
            state_nxt   = FETCH_WAIT;
          end
        end
      end
      FETCH_WAIT: begin
        // Ack takes priority over an expiring timeout in the same cycle
        if (imem_ack) begin
          if (aborted) begin
            drop      = 1'b1;
            state_nxt = FETCH_IDLE;
          end else begin
            accept    = 1'b1;
            state_nxt = FETCH_HOLD;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          timed_out = 1'b1;
          state_nxt = FETCH_IDLE;
        end
      end
      FETCH_HOLD: begin
        if (flush || decode_ready) state_nxt = FETCH_IDLE;
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge fetch_reset) begin
    if (fetch_reset) begin
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= DATA_W'(NOP_INSTR);
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      err_pc      <= '0;
      tmo_cnt     <= '0;
      flushed     <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      if (misaligned) begin
        fetch_err <= 1'b1;
        err_pc    <= pc_in;
      end
      if (start_fetch) begin
        imem_addr <= pc_in;
        imem_req  <= 1'b1;
        tmo_cnt   <= '0;
        flushed   <= 1'b0;
      end
      if (state == FETCH_WAIT) begin
        if (accept || drop || timed_out) begin
          imem_req <= 1'b0;
          flushed  <= 1'b0;
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (flush) flushed <= 1'b1;
        end
      end
      if (accept) begin
        instr       <= imem_rdata;
        instr_pc    <= imem_addr;
        instr_valid <= 1'b1;
      end
      if (timed_out && !aborted) begin
        fetch_err <= 1'b1;
        err_pc    <= imem_addr;
      end
      if (state == FETCH_HOLD && state_nxt == FETCH_IDLE) instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized fetch transactions
// checked against a transaction-level expectation model.
module tb_fetch_unit;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              fetch_reset;
  logic [ADDR_W-1:0] pc_in;
  logic              fetch_en;
  logic              flush;
  logic              pc_write_en;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              decode_ready;
  logic              fetch_err;
  logic [ADDR_W-1:0] err_pc;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] model_err_pc = '0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .fetch_reset(fetch_reset), .pc_in(pc_in), .fetch_en(fetch_en),
    .flush(flush), .pc_write_en(pc_write_en), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .decode_ready(decode_ready), .fetch_err(fetch_err), .err_pc(err_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch from IDLE. d = cycle of WAIT (1-based) in which ack is driven,
  // fl = WAIT cycle carrying a flush pulse (0 = none).
  task automatic fetch_txn(input logic [31:0] pc, input logic [31:0] data, input int d,
                           input int fl, input int stall, input bit hold_flush);
    int last;
    bit acked, aborted;
    last    = (d < TIMEOUT) ? d : TIMEOUT;
    acked   = (d <= TIMEOUT);
    aborted = (fl >= 1) && (fl <= last);
    fetch_en = 1'b1;
    pc_in    = pc;
    #1;
    chk("idle_pcwe", pc_write_en, 0);
    step();
    fetch_en = 1'b0;
    pc_in    = $urandom;
    for (int k = 1; k <= last; k++) begin
      flush      = (k == fl);
      imem_ack   = (k == d);
      imem_rdata = (k == d) ? data : $urandom;
      #1;
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, pc);
      chk("wait_valid", instr_valid, 0);
      chk("wait_err", fetch_err, 0);
      chk("wait_pcwe", pc_write_en, 0);
      step();
    end
    flush    = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("end_req", imem_req, 0);
    chk("end_valid", instr_valid, acked && !aborted);
    chk("end_err", fetch_err, !acked && !aborted);
    if (!acked && !aborted) model_err_pc = pc;
    chk("err_pc", err_pc, model_err_pc);
    if (acked && !aborted) begin
      for (int s = 0; s < stall; s++) begin
        decode_ready = 1'b0;
        #1;
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, data);
        chk("hold_pc", instr_pc, pc);
        chk("hold_pcwe", pc_write_en, 0);
        step();
      end
      decode_ready = 1'b1;
      flush        = hold_flush;
      #1;
      chk("take_valid", instr_valid, 1);
      chk("take_instr", instr, data);
      chk("take_pcwe", pc_write_en, !hold_flush);
      step();
      decode_ready = 1'b0;
      flush        = 1'b0;
      #1;
      chk("after_valid", instr_valid, 0);
      chk("after_pcwe", pc_write_en, 0);
      chk("after_req", imem_req, 0);
    end
  endtask

  task automatic misaligned_txn(input logic [31:0] pc, input bit with_flush);
    fetch_en = 1'b1;
    flush    = with_flush;
    pc_in    = pc;
    step();
    fetch_en = 1'b0;
    flush    = 1'b0;
    #1;
    chk("mis_req", imem_req, 0);
    chk("mis_err", fetch_err, !with_flush);
    if (!with_flush) model_err_pc = pc;
    chk("mis_err_pc", err_pc, model_err_pc);
    step();
    chk("mis_err_drop", fetch_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, data;
    int d, fl;
    fetch_reset  = 1'b1;
    pc_in        = '0;
    fetch_en     = 1'b0;
    flush        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    decode_ready = 1'b0;
    step();
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_err_pc", err_pc, 0);
    chk("rst_pcwe", pc_write_en, 0);
    fetch_reset = 1'b0;
    step();

    // Directed scenarios
    fetch_txn(32'h0040_0000, 32'h2008_000A, 3, 0, 0, 1'b0);
    misaligned_txn(32'h0040_0002, 1'b0);
    fetch_txn(32'h0040_0010, 32'h1234_5678, 40, 0, 0, 1'b0);
    step();
    fetch_txn(32'h0040_0020, 32'hDEAD_BEEF, 4, 2, 0, 1'b0);
    fetch_txn(32'h0040_0024, 32'hCAFE_0001, 2, 0, 0, 1'b0);
    fetch_txn(32'h0040_0028, 32'h0BAD_F00D, 1, 0, 5, 1'b0);
    fetch_txn(32'h0040_002C, 32'h5555_AAAA, TIMEOUT, 0, 1, 1'b0);
    fetch_txn(32'h0040_0030, 32'h7777_1111, 3, 0, 2, 1'b1);
    fetch_txn(32'h0040_0034, 32'h0, 30, 5, 0, 1'b0);
    misaligned_txn(32'h0040_0003, 1'b1);

    // Asynchronous reset in the middle of WAIT
    fetch_en = 1'b1;
    pc_in    = 32'h0040_0100;
    step();
    fetch_en = 1'b0;
    step();
    chk("prereset_req", imem_req, 1);
    #2;
    fetch_reset = 1'b1;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_valid", instr_valid, 0);
    model_err_pc = '0;
    step();
    fetch_reset = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hFFFF_0000;
    step();
    imem_ack = 1'b0;
    #1;
    chk("late_ack_valid", instr_valid, 0);
    chk("late_ack_req", imem_req, 0);
    chk("late_ack_err", fetch_err, 0);

    // Asynchronous reset while holding an instruction
    fetch_en = 1'b1;
    pc_in    = 32'h0040_0200;
    step();
    fetch_en   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0F0F_0F0F;
    step();
    imem_ack = 1'b0;
    #1;
    chk("hold_before_rst", instr_valid, 1);
    fetch_reset = 1'b1;
    #1;
    chk("async_hold_valid", instr_valid, 0);
    chk("async_hold_instr", instr, 0);
    step();
    fetch_reset = 1'b0;
    step();

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      pc   = $urandom;
      data = $urandom;
      if (($urandom % 6) == 0) begin
        if (pc[1:0] == 2'b00) pc[0] = 1'b1;
        misaligned_txn(pc, ($urandom % 4) == 0);
      end else begin
        pc[1:0] = 2'b00;
        d  = $urandom_range(1, TIMEOUT + 4);
        fl = (($urandom % 4) == 0) ? $urandom_range(1, d) : 0;
        fetch_txn(pc, data, d, fl, $urandom_range(0, 4), ($urandom % 5) == 0);
      end
      if ($urandom % 2) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer side of the program-counter register: takes the current PC value and fetches the instruction at that address from instruction memory over a req/ack handshake.
- Hands the instruction to decode with a valid/ready handshake.
- Tells the PC register when it may load its next value.
- Sits between the PC register, instruction memory and the decode stage. Handles misaligned PCs, memory timeouts and branch flushes.

Parameters:
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- TIMEOUT, 16, cycles to wait for imem_ack before flagging an error (1..255).

Ports:
- clk  in  1  rising-edge clock
- fetch_reset  in  1  reset; asynchronous, active-high, acts on posedge clk or posedge fetch_reset
- pc_in  in  ADDR_W  current PC value from the PC register
- fetch_en  in  1  start a fetch when idle
- flush  in  1  redirect/abort the current fetch (branch taken)
- pc_write_en  out  1  PC register may load its next value this cycle
- imem_req  out  1  memory request, held until ack
- imem_addr  out  ADDR_W  word address, stable while imem_req=1
- imem_ack  in  1  memory response valid
- imem_rdata  in  DATA_W  instruction word, valid with imem_ack
- instr  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  PC of instr
- instr_valid  out  1  instr/instr_pc valid for decode
- decode_ready  in  1  decode accepts instr
- fetch_err  out  1  one-cycle pulse: misaligned PC or timeout
- err_pc  out  ADDR_W  PC associated with last error

Behaviour:
- Reset state:
  - state=IDLE.
  - imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, fetch_err=0, err_pc=0.
  - Timeout counter=0, flushed flag=0.
  - Reset mid-transaction drops imem_req immediately (asynchronous). A late ack is ignored because the block is in IDLE.
- States:
  - IDLE: imem_ack is ignored.
    - fetch_en=1, flush=0, pc_in[1:0]!=0: fetch_err=1 next cycle, err_pc=pc_in, stay IDLE.
    - fetch_en=1, flush=0, pc_in aligned: imem_addr<=pc_in, imem_req<=1, counter<=0, go WAIT.
  - WAIT:
    - imem_req=1 and imem_addr held.
    - Counter increments each cycle without ack.
    - flush=1 sets the flushed flag. The request cannot be cancelled.
    - On imem_ack, with flushed=0 and flush=0: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, imem_req<=0, go HOLD.
    - On imem_ack, with flushed=1 or flush=1: discard data, imem_req<=0, clear flag, go IDLE.
    - Counter reaching TIMEOUT-1 with no ack: imem_req<=0, go IDLE. fetch_err pulse and err_pc=imem_addr, unless flushed (then no error).
    - Ack wins over timeout in the same cycle.
  - HOLD:
    - instr_valid=1.
    - decode_ready=1 and flush=0: instr_valid<=0, go IDLE.
    - flush=1 (with or without decode_ready): instr_valid<=0, go IDLE, data dropped.
- pc_write_en: combinational, = (state==HOLD) & decode_ready & ~flush. It is high for exactly one cycle per consumed instruction.
- flush does not drive pc_write_en; the PC redirect path owns PC loading on a flush.
- Latency:
  - fetch_en at cycle N gives imem_req high at N+1.
  - imem_ack at cycle M gives instr_valid at M+1.
  - Minimum fetch-to-valid is 2 cycles.
- instr/instr_pc stay stable while instr_valid=1.
- fetch_err is never asserted together with instr_valid rising.

Decomposition:
- Shared package (cpu_defs):
  - FETCH_IDLE/FETCH_WAIT/FETCH_HOLD state encodings (2 bits).
  - Default ADDR_W/DATA_W.
  - NOP instruction constant 32'h0000_0000.
- No sub-module; counter and FSM are small enough to stay in one module.

Test Plan:
- Reset then fetch_en with pc_in=0x00400000; memory acks 3 cycles after req with 0x2008000A.
  - imem_req high for 3 cycles, imem_addr=0x00400000.
  - instr_valid next cycle with instr=0x2008000A, instr_pc=0x00400000.
  - decode_ready=1 gives pc_write_en=1 for one cycle, then IDLE.
- pc_in=0x00400002 with fetch_en: no imem_req; fetch_err pulses 1 cycle, err_pc=0x00400002.
- Memory never acks, TIMEOUT=16: imem_req drops after 16 cycles; fetch_err=1 for one cycle, err_pc=request address.
- flush one cycle after req, ack 2 cycles later with 0xDEADBEEF: instr_valid never rises, pc_write_en stays 0, back in IDLE; next fetch works normally.
- Hold decode_ready=0 for 5 cycles in HOLD: instr/instr_pc stable, pc_write_en=0 throughout; decode_ready=1 gives a single pc_write_en pulse.
- Assert fetch_reset asynchronously mid-WAIT: imem_req and instr_valid go 0 before the next clock edge; a subsequent ack is ignored.
